// File: rtl/serv_fetch_seq.sv
// ----------------------------------------------------------------------------
// serv_fetch_seq
//
// Instruction fetch sequencer between the ibus Wishbone port and serv_decode.
// It fetches one instruction, latches the word, and strobes the decoder
// enable for one cycle. In the cycle after the strobe it samples the decoder's
// ebreak/wfi results. From those results it decides to run, to sleep until an
// interrupt arrives, or to halt for debug. A wait-state counter aborts a fetch
// that never gets an ack and parks the sequencer in HALT.
//
// Ports:
//   clk          clock
//   i_rst        synchronous active-high reset
//   o_ibus_adr   fetch address, bits [1:0] always zero
//   o_ibus_cyc   ibus request
//   i_ibus_rdt   fetch data
//   i_ibus_ack   fetch acknowledge
//   o_dec_rdt    latched instruction bits [31:2], to decoder i_wb_rdt
//   o_dec_en     one-cycle decode strobe, to decoder i_wb_en
//   i_ebreak     decoder o_ebreak
//   i_wfi        decoder o_wfi
//   i_pc_next    next PC from the core, bits [1:0] ignored
//   i_pc_valid   core finished the instruction, i_pc_next valid
//   i_irq        pending interrupt (level)
//   i_resume     debug resume (level or pulse)
//   o_sleep      high while sleeping
//   o_halted     high while halted
//   o_fetch_err  one-cycle pulse on fetch timeout
// ----------------------------------------------------------------------------
module serv_fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic        clk,
  input  logic        i_rst,
  output logic [31:0] o_ibus_adr,
  output logic        o_ibus_cyc,
  input  logic [31:0] i_ibus_rdt,
  input  logic        i_ibus_ack,
  output logic [29:0] o_dec_rdt,
  output logic        o_dec_en,
  input  logic        i_ebreak,
  input  logic        i_wfi,
  input  logic [31:0] i_pc_next,
  input  logic        i_pc_valid,
  input  logic        i_irq,
  input  logic        i_resume,
  output logic        o_sleep,
  output logic        o_halted,
  output logic        o_fetch_err
);

  typedef enum logic [2:0] {
    BOOT   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    CHECK  = 3'd3,
    EXEC   = 3'd4,
    SLEEP  = 3'd5,
    HALT   = 3'd6
  } state_t;

  // The low address bits are forced to zero so that a misaligned RESET_PC
  // can never reach the bus.
  localparam logic [31:0] ResetAdr   = {RESET_PC[31:2], 2'b00};
  localparam logic [7:0]  TimeoutLast = TIMEOUT - 8'd1;
  localparam bit          TimeoutOn   = (TIMEOUT != 8'd0);

  state_t      state_q,     state_d;
  logic [31:0] ibusAdr_q,   ibusAdr_d;
  logic        ibusCyc_q,   ibusCyc_d;
  logic [29:0] decRdt_q,    decRdt_d;
  logic        decEn_q,     decEn_d;
  logic        sleep_q,     sleep_d;
  logic        halted_q,    halted_d;
  logic        fetchErr_q,  fetchErr_d;
  logic        wfiFlag_q,   wfiFlag_d;
  logic [7:0]  waitCnt_q,   waitCnt_d;

  logic        timeoutHit;

  // The timeout fires on the last allowed wait cycle. Because an ack is
  // checked first in the FETCH branch below, an ack in that same cycle wins.
  assign timeoutHit = TimeoutOn && (waitCnt_q == TimeoutLast);

  // Next-state logic. Every output is produced as a register value, so each
  // transition also sets the output values for the state it enters. For
  // example, cyc rises on the edge that enters FETCH, so the request is
  // visible in the first FETCH cycle.
  always_comb begin
    state_d    = state_q;
    ibusAdr_d  = ibusAdr_q;
    ibusCyc_d  = ibusCyc_q;
    decRdt_d   = decRdt_q;
    decEn_d    = 1'b0;
    sleep_d    = sleep_q;
    halted_d   = halted_q;
    fetchErr_d = 1'b0;
    wfiFlag_d  = wfiFlag_q;
    waitCnt_d  = waitCnt_q;

    unique case (state_q)
      BOOT: begin
        ibusCyc_d = 1'b1;
        waitCnt_d = 8'd0;
        state_d   = FETCH;
      end

      FETCH: begin
        if (i_ibus_ack) begin
          decRdt_d  = i_ibus_rdt[31:2];
          ibusCyc_d = 1'b0;
          waitCnt_d = 8'd0;
          decEn_d   = 1'b1;
          state_d   = DECODE;
        end else if (timeoutHit) begin
          ibusCyc_d  = 1'b0;
          waitCnt_d  = 8'd0;
          fetchErr_d = 1'b1;
          halted_d   = 1'b1;
          state_d    = HALT;
        end else begin
          waitCnt_d = waitCnt_q + 8'd1;
        end
      end

      DECODE: begin
        state_d = CHECK;
      end

      // The decoder outputs are valid here. An interrupt that is already
      // pending makes the wfi act as a nop.
      CHECK: begin
        if (i_ebreak) begin
          halted_d = 1'b1;
          state_d  = HALT;
        end else begin
          wfiFlag_d = i_wfi & ~i_irq;
          state_d   = EXEC;
        end
      end

      // A late interrupt arriving during EXEC still cancels the sleep.
      EXEC: begin
        if (i_pc_valid) begin
          ibusAdr_d = {i_pc_next[31:2], 2'b00};
          wfiFlag_d = 1'b0;
          if (wfiFlag_q && !i_irq) begin
            sleep_d = 1'b1;
            state_d = SLEEP;
          end else begin
            ibusCyc_d = 1'b1;
            state_d   = FETCH;
          end
        end
      end

      // On wake, the fetch reuses the address that was latched in EXEC.
      SLEEP: begin
        if (i_irq) begin
          sleep_d   = 1'b0;
          ibusCyc_d = 1'b1;
          waitCnt_d = 8'd0;
          state_d   = FETCH;
        end
      end

      // On resume, the core supplies the next PC through EXEC.
      HALT: begin
        if (i_resume) begin
          halted_d = 1'b0;
          state_d  = EXEC;
        end
      end

      default: begin
        ibusCyc_d = 1'b0;
        sleep_d   = 1'b0;
        halted_d  = 1'b0;
        state_d   = BOOT;
      end
    endcase
  end

  // State and output registers. Reset returns everything to the boot values
  // from any state, so an ack that arrives just after reset finds BOOT and
  // is dropped.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q    <= BOOT;
      ibusAdr_q  <= ResetAdr;
      ibusCyc_q  <= 1'b0;
      decRdt_q   <= 30'd0;
      decEn_q    <= 1'b0;
      sleep_q    <= 1'b0;
      halted_q   <= 1'b0;
      fetchErr_q <= 1'b0;
      wfiFlag_q  <= 1'b0;
      waitCnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      ibusAdr_q  <= ibusAdr_d;
      ibusCyc_q  <= ibusCyc_d;
      decRdt_q   <= decRdt_d;
      decEn_q    <= decEn_d;
      sleep_q    <= sleep_d;
      halted_q   <= halted_d;
      fetchErr_q <= fetchErr_d;
      wfiFlag_q  <= wfiFlag_d;
      waitCnt_q  <= waitCnt_d;
    end
  end

  assign o_ibus_adr  = ibusAdr_q;
  assign o_ibus_cyc  = ibusCyc_q;
  assign o_dec_rdt   = decRdt_q;
  assign o_dec_en    = decEn_q;
  assign o_sleep     = sleep_q;
  assign o_halted    = halted_q;
  assign o_fetch_err = fetchErr_q;

endmodule

// File: tb/tb_serv_fetch_seq.sv
// ----------------------------------------------------------------------------
// tb_serv_fetch_seq
//
// Directed bench for serv_fetch_seq. The DUT uses a short timeout of 4 and a
// non-zero reset PC, so both values show up in the observed outputs.
// ----------------------------------------------------------------------------
module tb_serv_fetch_seq;

  localparam logic [31:0] ResetPc = 32'h0000_0080;

  logic        clk;
  logic        i_rst;
  logic [31:0] o_ibus_adr;
  logic        o_ibus_cyc;
  logic [31:0] i_ibus_rdt;
  logic        i_ibus_ack;
  logic [29:0] o_dec_rdt;
  logic        o_dec_en;
  logic        i_ebreak;
  logic        i_wfi;
  logic [31:0] i_pc_next;
  logic        i_pc_valid;
  logic        i_irq;
  logic        i_resume;
  logic        o_sleep;
  logic        o_halted;
  logic        o_fetch_err;

  int errorCount = 0;
  int checkCount = 0;

  serv_fetch_seq #(
    .RESET_PC(ResetPc),
    .TIMEOUT (8'd4)
  ) dut (
    .clk        (clk),
    .i_rst      (i_rst),
    .o_ibus_adr (o_ibus_adr),
    .o_ibus_cyc (o_ibus_cyc),
    .i_ibus_rdt (i_ibus_rdt),
    .i_ibus_ack (i_ibus_ack),
    .o_dec_rdt  (o_dec_rdt),
    .o_dec_en   (o_dec_en),
    .i_ebreak   (i_ebreak),
    .i_wfi      (i_wfi),
    .i_pc_next  (i_pc_next),
    .i_pc_valid (i_pc_valid),
    .i_irq      (i_irq),
    .i_resume   (i_resume),
    .o_sleep    (o_sleep),
    .o_halted   (o_halted),
    .o_fetch_err(o_fetch_err)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports the observed and expected values when
  // they differ.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advances one clock. Outputs are sampled and inputs are changed 1 unit
  // after the rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Presents an ack with the given word during the current FETCH cycle, then
  // moves into DECODE.
  task automatic applyStimulus(input logic [31:0] rdt);
    i_ibus_ack = 1'b1;
    i_ibus_rdt = rdt;
    nextCycle();
    i_ibus_ack = 1'b0;
    i_ibus_rdt = 32'h0;
  endtask

  // From EXEC, reports a finished instruction with the given next PC.
  task automatic finishInstr(input logic [31:0] pc);
    i_pc_valid = 1'b1;
    i_pc_next  = pc;
    nextCycle();
    i_pc_valid = 1'b0;
    i_pc_next  = 32'h0;
  endtask

  initial begin
    int badCycles;

    i_rst      = 1'b1;
    i_ibus_rdt = 32'h0;
    i_ibus_ack = 1'b0;
    i_ebreak   = 1'b0;
    i_wfi      = 1'b0;
    i_pc_next  = 32'h0;
    i_pc_valid = 1'b0;
    i_irq      = 1'b0;
    i_resume   = 1'b0;
    nextCycle();
    nextCycle();

    checkOutput("rst_cyc",    32'(o_ibus_cyc),  32'd0);
    checkOutput("rst_adr",    o_ibus_adr,       ResetPc);
    checkOutput("rst_decrdt", 32'(o_dec_rdt),   32'd0);
    checkOutput("rst_decen",  32'(o_dec_en),    32'd0);
    checkOutput("rst_sleep",  32'(o_sleep),     32'd0);
    checkOutput("rst_halted", 32'(o_halted),    32'd0);
    checkOutput("rst_err",    32'(o_fetch_err), 32'd0);

    // NOP with zero wait states. Cycle 1 is BOOT, and cyc rises in cycle 2.
    i_rst = 1'b0;
    nextCycle();
    checkOutput("boot_cyc",   32'(o_ibus_cyc), 32'd1);
    checkOutput("boot_adr",   o_ibus_adr,      ResetPc);
    applyStimulus(32'h0000_0013);
    checkOutput("nop_decen",  32'(o_dec_en),   32'd1);
    checkOutput("nop_decrdt", 32'(o_dec_rdt),  32'h0000_0004);
    checkOutput("nop_cycoff", 32'(o_ibus_cyc), 32'd0);
    nextCycle();
    checkOutput("nop_decen_once", 32'(o_dec_en), 32'd0);
    nextCycle();
    checkOutput("nop_exec_idle",
                {29'd0, o_ibus_cyc, o_sleep, o_halted}, 32'd0);
    finishInstr(32'h0000_0006);
    checkOutput("nop_next_cyc", 32'(o_ibus_cyc), 32'd1);
    checkOutput("nop_next_adr", o_ibus_adr,      32'h0000_0004);

    // ebreak halts. pc_valid during HALT is ignored, and resume returns to EXEC.
    applyStimulus(32'h0010_0073);
    checkOutput("ebrk_decrdt", 32'(o_dec_rdt), 32'h0004_001C);
    nextCycle();
    i_ebreak = 1'b1;
    nextCycle();
    i_ebreak = 1'b0;
    checkOutput("ebrk_halted", 32'(o_halted),   32'd1);
    checkOutput("ebrk_nocyc",  32'(o_ibus_cyc), 32'd0);
    finishInstr(32'h0000_0200);
    checkOutput("ebrk_pcv_ignored", o_ibus_adr,    32'h0000_0004);
    checkOutput("ebrk_still_halt",  32'(o_halted), 32'd1);
    i_resume = 1'b1;
    nextCycle();
    i_resume = 1'b0;
    checkOutput("resume_halted", 32'(o_halted),   32'd0);
    checkOutput("resume_nocyc",  32'(o_ibus_cyc), 32'd0);
    finishInstr(32'h0000_0100);
    checkOutput("resume_cyc", 32'(o_ibus_cyc), 32'd1);
    checkOutput("resume_adr", o_ibus_adr,      32'h0000_0100);

    // wfi with no interrupt pending: sleep, stay idle, then wake on irq.
    applyStimulus(32'h1050_0073);
    checkOutput("wfi_decrdt", 32'(o_dec_rdt), 32'h0414_001C);
    nextCycle();
    i_wfi = 1'b1;
    nextCycle();
    i_wfi = 1'b0;
    finishInstr(32'h0000_0104);
    checkOutput("wfi_sleep", 32'(o_sleep),    32'd1);
    checkOutput("wfi_nocyc", 32'(o_ibus_cyc), 32'd0);
    badCycles = 0;
    for (int i = 0; i < 20; i++) begin
      nextCycle();
      if (o_ibus_cyc !== 1'b0 || o_sleep !== 1'b1) badCycles++;
    end
    checkOutput("wfi_sleep_hold", 32'(badCycles), 32'd0);
    i_irq = 1'b1;
    nextCycle();
    i_irq = 1'b0;
    checkOutput("wake_cyc",   32'(o_ibus_cyc), 32'd1);
    checkOutput("wake_sleep", 32'(o_sleep),    32'd0);
    checkOutput("wake_adr",   o_ibus_adr,      32'h0000_0104);

    // wfi with irq already pending in CHECK: no sleep.
    applyStimulus(32'h1050_0073);
    nextCycle();
    i_wfi = 1'b1;
    i_irq = 1'b1;
    nextCycle();
    i_wfi = 1'b0;
    i_irq = 1'b0;
    finishInstr(32'h0000_0108);
    checkOutput("wfiirq_sleep", 32'(o_sleep),    32'd0);
    checkOutput("wfiirq_cyc",   32'(o_ibus_cyc), 32'd1);
    checkOutput("wfiirq_adr",   o_ibus_adr,      32'h0000_0108);

    // Timeout: no ack, so cyc stays high for exactly 4 cycles.
    badCycles = 0;
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      if (o_ibus_cyc !== 1'b1) badCycles++;
    end
    checkOutput("to_cyc_held", 32'(badCycles), 32'd0);
    nextCycle();
    checkOutput("to_cyc_drop", 32'(o_ibus_cyc),  32'd0);
    checkOutput("to_err",      32'(o_fetch_err), 32'd1);
    checkOutput("to_halted",   32'(o_halted),    32'd1);
    nextCycle();
    checkOutput("to_err_pulse",  32'(o_fetch_err), 32'd0);
    checkOutput("to_halted_hold", 32'(o_halted),   32'd1);
    i_resume = 1'b1;
    nextCycle();
    i_resume = 1'b0;
    finishInstr(32'h0000_010C);
    checkOutput("to_refetch_adr", o_ibus_adr, 32'h0000_010C);

    // An ack on the 4th wait cycle wins over the timeout.
    nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("to4_cyc", 32'(o_ibus_cyc), 32'd1);
    applyStimulus(32'h0000_0013);
    checkOutput("to4_decen",  32'(o_dec_en),    32'd1);
    checkOutput("to4_noerr",  32'(o_fetch_err), 32'd0);
    checkOutput("to4_nohalt", 32'(o_halted),    32'd0);
    nextCycle();
    nextCycle();
    checkOutput("to4_exec_nohalt", 32'(o_halted), 32'd0);
    finishInstr(32'h0000_0110);
    checkOutput("to4_next_adr", o_ibus_adr, 32'h0000_0110);

    // Reset mid-FETCH. A late ack during BOOT is dropped.
    i_rst = 1'b1;
    nextCycle();
    i_rst = 1'b0;
    checkOutput("mid_rst_cyc",    32'(o_ibus_cyc), 32'd0);
    checkOutput("mid_rst_adr",    o_ibus_adr,      ResetPc);
    checkOutput("mid_rst_decrdt", 32'(o_dec_rdt),  32'd0);
    applyStimulus(32'h0000_0013);
    checkOutput("late_ack_decen",  32'(o_dec_en),   32'd0);
    checkOutput("late_ack_decrdt", 32'(o_dec_rdt),  32'd0);
    checkOutput("refetch_cyc",     32'(o_ibus_cyc), 32'd1);
    checkOutput("refetch_adr",     o_ibus_adr,      ResetPc);
    nextCycle();
    checkOutput("refetch_still_cyc", 32'(o_ibus_cyc), 32'd1);
    checkOutput("refetch_no_decen",  32'(o_dec_en),   32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
